// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between MEM/WB and a long-latency unit; long results queue in a
// small FIFO and drain into idle writeback slots, with a pending-register scoreboard for ID stalls.
module rf_wport_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_we_i,
  input  logic [4:0]                   wb_addr_i,
  input  logic [31:0]                  wb_data_i,
  input  logic                         lu_issue_i,
  input  logic [4:0]                   lu_issue_addr_i,
  input  logic                         lu_valid_i,
  input  logic [4:0]                   lu_addr_i,
  input  logic [31:0]                  lu_data_i,
  output logic                         lu_ready_o,
  input  logic [4:0]                   id_rs_i,
  input  logic [4:0]                   id_rt_i,
  input  logic [4:0]                   id_rd_i,
  input  logic                         id_rd_we_i,
  output logic                         id_stall_o,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [31:0]                  rf_wdata_o,
  output logic [$clog2(DEPTH):0]       pend_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   sb_q, sb_d;
  logic          wb_eff, fifo_nempty, pop, push;

  assign wb_eff      = wb_we_i && (wb_addr_i != 5'd0);
  assign fifo_nempty = (cnt_q != '0);
  assign pop         = !wb_eff && fifo_nempty;
  assign lu_ready_o  = (cnt_q < CW'(DEPTH));
  // A result to r0 completes the handshake but is dropped.
  assign push        = lu_valid_i && lu_ready_o && (lu_addr_i != 5'd0);
  assign pend_cnt_o  = cnt_q;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (wb_eff) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_addr_i;
      rf_wdata_o = wb_data_i;
    end else if (fifo_nempty) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = fifo_addr_q[rd_ptr_q];
      rf_wdata_o = fifo_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Clear is applied before set so a re-issue to the draining register keeps it pending.
  always_comb begin
    sb_d = sb_q;
    if (pop) sb_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
    if (lu_issue_i && (lu_issue_addr_i != 5'd0)) sb_d[lu_issue_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  assign id_stall_o = ((id_rs_i != 5'd0) && sb_q[id_rs_i]) ||
                      ((id_rt_i != 5'd0) && sb_q[id_rt_i]) ||
                      (id_rd_we_i && (id_rd_i != 5'd0) && sb_q[id_rd_i]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      sb_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      sb_q  <= sb_d;
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= lu_addr_i;
        fifo_data_q[wr_ptr_q] <= lu_data_i;
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized and directed bench for rf_wport_arbiter against a queue-based reference model.
module tb_rf_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_we = 1'b0;
  logic [4:0]    wb_addr = '0;
  logic [31:0]   wb_data = '0;
  logic          lu_issue = 1'b0;
  logic [4:0]    lu_issue_addr = '0;
  logic          lu_valid = 1'b0;
  logic [4:0]    lu_addr = '0;
  logic [31:0]   lu_data = '0;
  logic          lu_ready;
  logic [4:0]    id_rs = '0, id_rt = '0, id_rd = '0;
  logic          id_rd_we = 1'b0;
  logic          id_stall;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [CW-1:0] pend_cnt;

  rf_wport_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .lu_issue_i(lu_issue), .lu_issue_addr_i(lu_issue_addr),
    .lu_valid_i(lu_valid), .lu_addr_i(lu_addr), .lu_data_i(lu_data), .lu_ready_o(lu_ready),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_rd_we_i(id_rd_we),
    .id_stall_o(id_stall),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .pend_cnt_o(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];     // results the model holds, oldest first
  ent_t        req_q[$];  // results the long unit wants to deliver, held until accepted
  logic [31:0] msb;       // pending registers in the model
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [4:0] a, input logic [31:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    return e;
  endfunction

  // Called on a negedge with all inputs except lu_* already set; returns on the next negedge.
  task automatic cycle();
    bit         weff, exp_rdy, exp_stall;
    ent_t       head;
    if (req_q.size() > 0) begin
      lu_valid = 1'b1; lu_addr = req_q[0].a; lu_data = req_q[0].d;
    end else begin
      lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    end
    #1;
    weff    = wb_we && (wb_addr != 0);
    exp_rdy = mq.size() < DEPTH;
    check("lu_ready", 32'(lu_ready), 32'(exp_rdy));
    check("pend_cnt", 32'(pend_cnt), 32'(mq.size()));
    if (weff) begin
      check("rf_we", 32'(rf_we), 32'd1);
      check("rf_waddr", 32'(rf_waddr), 32'(wb_addr));
      check("rf_wdata", rf_wdata, wb_data);
    end else if (mq.size() > 0) begin
      head = mq[0];
      check("rf_we", 32'(rf_we), 32'd1);
      check("rf_waddr", 32'(rf_waddr), 32'(head.a));
      check("rf_wdata", rf_wdata, head.d);
    end else begin
      check("rf_we", 32'(rf_we), 32'd0);
      check("rf_waddr", 32'(rf_waddr), 32'd0);
      check("rf_wdata", rf_wdata, 32'd0);
    end
    exp_stall = (id_rs != 0 && msb[id_rs]) || (id_rt != 0 && msb[id_rt]) ||
                (id_rd_we && id_rd != 0 && msb[id_rd]);
    check("id_stall", 32'(id_stall), 32'(exp_stall));
    @(posedge clk);
    if (!weff && mq.size() > 0) begin
      msb[mq[0].a] = 1'b0;
      void'(mq.pop_front());
    end
    if (lu_valid && exp_rdy) begin
      if (lu_addr != 0) mq.push_back(req_q[0]);
      void'(req_q.pop_front());
    end
    if (lu_issue && lu_issue_addr != 0) msb[lu_issue_addr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_addr = 0; wb_data = 0; lu_issue = 0; lu_issue_addr = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_rd_we = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_lu_ready"}, 32'(lu_ready), 32'd1);
    check({tag, "_pend_cnt"}, 32'(pend_cnt), 32'd0);
    check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
    check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    check({tag, "_id_stall"}, 32'(id_stall), 32'd0);
  endtask

  initial begin
    msb = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Issue r5, result two cycles later; ID reads r5 throughout.
    lu_issue = 1; lu_issue_addr = 5; id_rs = 5;
    cycle();
    lu_issue = 0;
    cycles(2);
    req_q.push_back(mk(5'd5, 32'hDEADBEEF));
    cycles(3);
    idle_inputs();

    // Three results against a busy writeback on r9.
    wb_we = 1; wb_addr = 9; wb_data = 32'h9999_0000;
    req_q.push_back(mk(5'd1, 32'h1111_1111));
    req_q.push_back(mk(5'd2, 32'h2222_2222));
    req_q.push_back(mk(5'd3, 32'h3333_3333));
    cycles(4);
    wb_we = 0;
    cycles(5);

    // Writeback to r0 leaves the port free for the queued r4.
    wb_we = 1; wb_addr = 9; wb_data = 32'h0BAD_F00D;
    req_q.push_back(mk(5'd4, 32'h4444_4444));
    cycles(2);
    wb_addr = 0;
    cycles(2);
    wb_we = 0;

    // Re-issue of r7 in the cycle its old result drains keeps r7 pending.
    lu_issue = 1; lu_issue_addr = 7;
    cycle();
    lu_issue = 0;
    wb_we = 1; wb_addr = 9;
    req_q.push_back(mk(5'd7, 32'h7777_7777));
    req_q.push_back(mk(5'd8, 32'h8888_8888));
    cycles(2);
    wb_we = 0;
    req_q.push_back(mk(5'd10, 32'hAAAA_AAAA));
    lu_issue = 1; lu_issue_addr = 7;
    cycle();
    lu_issue = 0; id_rs = 7;
    cycles(3);
    req_q.push_back(mk(5'd7, 32'h7070_7070));
    cycles(3);
    idle_inputs();

    // WAW term of the hazard check.
    lu_issue = 1; lu_issue_addr = 6;
    cycle();
    lu_issue = 0; id_rd = 6; id_rd_we = 1;
    cycle();
    id_rd_we = 0;
    cycle();
    id_rd = 0;
    cycle();
    req_q.push_back(mk(5'd6, 32'h6666_6666));
    cycles(3);

    // Asynchronous reset with two results queued.
    lu_issue = 1; lu_issue_addr = 12;
    cycle();
    lu_issue = 0; wb_we = 1; wb_addr = 9;
    req_q.push_back(mk(5'd12, 32'hC0C0_C0C0));
    req_q.push_back(mk(5'd13, 32'hD0D0_D0D0));
    cycles(2);
    check("full_before_reset", 32'(pend_cnt), 32'd2);
    idle_inputs();
    id_rs = 12;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    mq.delete(); req_q.delete(); msb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      wb_we         = ($urandom_range(0, 99) < 55);
      wb_addr       = 5'($urandom_range(0, 31));
      wb_data       = $urandom;
      lu_issue      = ($urandom_range(0, 99) < 30);
      lu_issue_addr = 5'($urandom_range(0, 31));
      id_rs         = 5'($urandom_range(0, 31));
      id_rt         = 5'($urandom_range(0, 31));
      id_rd         = 5'($urandom_range(0, 31));
      id_rd_we      = 1'($urandom_range(0, 1));
      if (req_q.size() < 2 && $urandom_range(0, 99) < 45)
        req_q.push_back(mk(5'($urandom_range(0, 31)), $urandom));
      cycle();
    end
    idle_inputs();
    cycles(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
